sram_bus_ctrl: RTL
==================

Name: sram_bus_ctrl

Overview:
Parametrised synchronous controller for an asynchronous SRAM on a shared bidirectional data bus. Takes single-word read/write requests from on-chip logic through a valid/ready handshake and runs SETUP/ACCESS/HOLD SRAM cycles with configurable wait states. Owns the tristate bus: drives it only during writes, releases it otherwise, and registers read data. Sits between Mem2IO-style client logic and the board SRAM pins.

Parameters:
DATA_W, 16, bus/word width; must be a multiple of 8
ADDR_W, 20, SRAM word-address width
WAIT_STATES, 2, ACCESS-phase length in cycles; legal range 1..15

Ports:
Clk  in  1  system clock; all logic on the rising edge
Reset  in  1  asynchronous, active-high reset
req  in  1  request valid
we  in  1  1 = write, 0 = read; sampled with req
addr  in  ADDR_W  word address; sampled with req
wdata  in  DATA_W  write data; sampled with req
be  in  DATA_W/8  byte enables, active high (used only under the optional feature)
ready  out  1  controller idle; request accepted on an edge where req && ready
rvalid  out  1  one-cycle pulse; rdata valid
rdata  out  DATA_W  registered read data; holds until the next read completes
wdone  out  1  one-cycle pulse; write cycle finished
sram_addr  out  ADDR_W  SRAM address
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low
sram_be_n  out  DATA_W/8  byte-lane enables, active low
Data  inout  DATA_W  SRAM data bus

Behaviour:
- Reset (async, immediate): state IDLE, ready=1, rvalid=0, wdone=0, rdata=0, sram_addr=0, ce_n/oe_n/we_n=1, be_n=all 1, Data=Z. Any in-flight transaction is dropped with no rvalid or wdone.
- All SRAM control outputs and the bus-drive enable are registered; no combinational path from req to the pins.
- FSM states: IDLE, SETUP, ACCESS, HOLD. ready=1 only in IDLE.
- IDLE: ce_n/oe_n/we_n=1, Data=Z. If req is high at edge E0, latch addr/we/wdata/be and go to SETUP.
- SETUP (1 cycle): sram_addr=latched addr, ce_n=0, be_n per lanes.
  - Read: oe_n=0.
  - Write: drive latched wdata, we_n=1.
  - Go to ACCESS with wait counter = WAIT_STATES-1.
- ACCESS (WAIT_STATES cycles): counter decrements each cycle.
  - Read: oe_n=0. On the edge where the counter is 0: rdata<=Data, rvalid<=1, go to IDLE.
  - Write: we_n=0, bus driven. On the edge where the counter is 0: go to HOLD.
- HOLD (write only, 1 cycle): we_n=1, ce_n=0, bus still driven. Then go to IDLE with wdone<=1 and the bus released on the same edge.
- Latency from acceptance edge E0:
  - Read: rvalid high in the cycle after edge E(1+WAIT_STATES).
  - Write: wdone high in the cycle after edge E(2+WAIT_STATES).
- Back-to-back: a new request may be accepted in the same cycle rvalid or wdone is high. The IDLE cycle between transactions is the mandatory bus turnaround; the bus is never driven while oe_n=0.
- req while ready=0 is ignored (not queued); the client holds req until accepted.
- sram_addr holds its last value in IDLE.

Optional Feature:
SRAM_BYTE_MASK_EN
- Defined: be is latched at acceptance. For writes, sram_be_n = ~be from SETUP through HOLD. A write with be=0 runs full timing with no lane enabled. Reads always enable all lanes.
- Undefined: be is ignored; sram_be_n = all 0 from SETUP through the end of the transaction. In both builds, sram_be_n = all 1 in IDLE/reset.

Test Plan:
1. Reset, WAIT_STATES=2, write addr=0x00012 data=0xBEEF -> SETUP/ACCESS/ACCESS/HOLD; we_n low exactly 2 cycles; Data=0xBEEF for 4 cycles; wdone pulse after E4; bus Z afterwards.
2. SRAM model returns 0xBEEF at 0x00012; read 0x00012 -> oe_n low 3 cycles; rvalid 1 cycle after E3 with rdata=0xBEEF; Data never driven by the DUT.
3. Write immediately followed by read (req held) -> exactly 1 IDLE cycle with Data=Z between the HOLD and read SETUP phases; no cycle with oe_n=0 while the DUT drives the bus.
4. Assert Reset during the ACCESS of a write -> same cycle: we_n=1, ce_n=1, Data=Z, ready=1; no wdone, no rvalid.
5. With SRAM_BYTE_MASK_EN, write 0x12AB with be=2'b01 -> sram_be_n=2'b10 during the transaction; only the low byte changes in the model. Without the macro, sram_be_n=2'b00.
6. WAIT_STATES=1, read -> rvalid after E2; req asserted while ready=0 -> ignored, no extra transaction.

Source files
------------

// File: rtl/sram_bus_ctrl.sv
`timescale 1ns/1ps
// sram_bus_ctrl
// Synchronous controller for an asynchronous SRAM on a shared bidirectional
// data bus. Single-word requests arrive on a valid/ready handshake; each
// request runs SETUP -> ACCESS (WAIT_STATES cycles) -> [HOLD, writes only]
// and returns to IDLE. The IDLE cycle between transactions is the bus
// turnaround: the controller drives Data only during writes.
//
// Ports:
//   Clk, Reset              rising-edge clock, async active-high reset
//   req/we/addr/wdata/be    request; sampled on the edge where req && ready
//   ready                   controller idle
//   rvalid/rdata            one-cycle read-complete pulse, registered data
//   wdone                   one-cycle write-complete pulse
//   sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n   SRAM pins
//   Data                    SRAM data bus (tristate)
//
// Build option: define SRAM_BYTE_MASK_EN to honour byte enables on writes;
// otherwise be is ignored and all lanes are enabled for every access.
module sram_bus_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_STATES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic                  ready,
  output logic                  rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  wdone,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [DATA_W/8-1:0]   sram_be_n,
  inout  wire  [DATA_W-1:0]     Data
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [BE_W-1:0]   be_n_q, be_n_d;
  logic              drive_q, drive_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              wdone_q, wdone_d;

  // Lane enables applied to a write accepted this cycle; registered into
  // be_n_q at acceptance and held for the whole transaction.
  logic [BE_W-1:0]   wr_lane_n;
`ifdef SRAM_BYTE_MASK_EN
  assign wr_lane_n = ~be;
`else
  logic unused_be;
  assign unused_be = ^be;
  assign wr_lane_n = '0;
`endif

  // NOTE: every _d gets a default at the top of the block so no path leaves
  // it unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ce_n_d   = ce_n_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;
    be_n_d   = be_n_q;
    drive_d  = drive_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wdone_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          // Pin values for SETUP are registered here, so nothing reaches
          // the pins combinationally from req.
          state_d = ST_SETUP;
          is_wr_d = we;
          addr_d  = addr;
          wdata_d = wdata;
          ce_n_d  = 1'b0;
          oe_n_d  = we;
          we_n_d  = 1'b1;
          be_n_d  = we ? wr_lane_n : '0;
          drive_d = we;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = CNT_INIT;
        if (is_wr_q) we_n_d = 1'b0;
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (is_wr_q) begin
            // Rising we_n commits the write; data stays on the bus in HOLD.
            state_d = ST_HOLD;
            we_n_d  = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            rdata_d  = Data;
            rvalid_d = 1'b1;
            ce_n_d   = 1'b1;
            oe_n_d   = 1'b1;
            be_n_d   = '1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        wdone_d = 1'b1;
        drive_d = 1'b0;
        ce_n_d  = 1'b1;
        be_n_d  = '1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      be_n_q   <= '1;
      drive_q  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      be_n_q   <= be_n_d;
      drive_q  <= drive_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign wdone     = wdone_q;
  assign sram_addr = addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_be_n = be_n_q;

  // Bus is driven only from a flop, so it releases on the same edge that
  // ends HOLD and can never overlap a read's oe_n window.
  assign Data = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule
